rs_pe: RTL and testbench

Row-stationary processing element, the parametrised successor to the fixed 3-tap PE in the systolic array. It loads a filter row and an ifmap row of runtime-selectable length into local register files and computes their dot product in a wide saturating accumulator. It can optionally add the psum from the PE below, and can reuse the stored filter across windows. All data movement uses valid/ready handshakes so the multicast controller and psum chain can stall it.

---
 rtl/rs_pe_if.sv | 42 ++++
 rtl/rs_pe.sv | 138 +++++++++++++
 tb/tb_rs_pe.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rs_pe_if.sv
// Handshake and job-configuration bundle between the array fabric and one rs_pe.
// The master modport drives jobs and operands; the slave modport is the PE side.
interface rs_pe_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int PSUM_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 3
);
  logic                         start;
  logic [RF_ADDR_WIDTH:0]       cfg_size;
  logic                         cfg_acc_psum;
  logic                         cfg_reuse_filter;
  logic                         ifmap_valid;
  logic                         ifmap_ready;
  logic signed [DATA_WIDTH-1:0] ifmap;
  logic                         filter_valid;
  logic                         filter_ready;
  logic signed [DATA_WIDTH-1:0] filter;
  logic                         in_psum_valid;
  logic                         in_psum_ready;
  logic signed [PSUM_WIDTH-1:0] input_psum;
  logic                         out_psum_valid;
  logic                         out_psum_ready;
  logic signed [PSUM_WIDTH-1:0] output_psum;
  logic                         sat;
  logic                         busy;

  modport master (
    output start, cfg_size, cfg_acc_psum, cfg_reuse_filter,
    output ifmap_valid, ifmap, filter_valid, filter,
    output in_psum_valid, input_psum, out_psum_ready,
    input  ifmap_ready, filter_ready, in_psum_ready,
    input  out_psum_valid, output_psum, sat, busy
  );

  modport slave (
    input  start, cfg_size, cfg_acc_psum, cfg_reuse_filter,
    input  ifmap_valid, ifmap, filter_valid, filter,
    input  in_psum_valid, input_psum, out_psum_ready,
    output ifmap_ready, filter_ready, in_psum_ready,
    output out_psum_valid, output_psum, sat, busy
  );
endinterface

// File: rtl/rs_pe.sv
// Row-stationary PE: loads N filter/ifmap taps, N-cycle saturating MAC, optional upstream psum add.
// Best case result 2N+1 cycles after start; every stream and the result stall on valid/ready.
module rs_pe #(
  parameter int DATA_WIDTH    = 16,
  parameter int PSUM_WIDTH    = 32,
  parameter int RF_ADDR_WIDTH = 3
) (
  input logic   clk,
  input logic   rstb,
  rs_pe_if.slave pe
);
  localparam int DEPTH = 2 ** RF_ADDR_WIDTH;
  localparam int CW    = RF_ADDR_WIDTH + 1;

  typedef logic signed [PSUM_WIDTH-1:0] psum_t;
  localparam psum_t PSUM_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam psum_t PSUM_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ACC, OUT} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] n_q, n_cfg, if_cnt_q, fl_cnt_q, if_cnt_nx, fl_cnt_nx, idx_q;
  logic          acc_psum_q, reuse_q, sat_q;
  logic signed [DATA_WIDTH-1:0] if_rf [DEPTH];
  logic signed [DATA_WIDTH-1:0] fl_rf [DEPTH];
  psum_t acc_q, out_q, f_ext, i_ext, prod, addend, sum;
  logic signed [PSUM_WIDTH:0] wide;
  logic sum_ovf, ifmap_hs, filter_hs, psum_hs, out_hs;
  logic [RF_ADDR_WIDTH-1:0] idx_a;

  // Readies depend only on registered state so no valid->ready path exists.
  assign pe.ifmap_ready    = (state_q == LOAD) && (if_cnt_q < n_q);
  assign pe.filter_ready   = (state_q == LOAD) && (fl_cnt_q < n_q) && !reuse_q;
  assign pe.in_psum_ready  = (state_q == ACC);
  assign pe.out_psum_valid = (state_q == OUT);
  assign pe.output_psum    = out_q;
  assign pe.sat            = sat_q;
  assign pe.busy           = (state_q != IDLE);

  assign ifmap_hs  = pe.ifmap_valid && pe.ifmap_ready;
  assign filter_hs = pe.filter_valid && pe.filter_ready;
  assign psum_hs   = pe.in_psum_valid && pe.in_psum_ready;
  assign out_hs    = pe.out_psum_valid && pe.out_psum_ready;
  assign if_cnt_nx = if_cnt_q + CW'(ifmap_hs);
  assign fl_cnt_nx = fl_cnt_q + CW'(filter_hs);
  assign idx_a     = idx_q[RF_ADDR_WIDTH-1:0];

  always_comb begin
    n_cfg = pe.cfg_size;
    if (pe.cfg_size == '0)
      n_cfg = CW'(1);
    else if (pe.cfg_size > CW'(DEPTH))
      n_cfg = CW'(DEPTH);
  end

  // One shared saturating adder: MAC products in MAC, the upstream psum in ACC.
  always_comb begin
    f_ext   = psum_t'(fl_rf[idx_a]);
    i_ext   = psum_t'(if_rf[idx_a]);
    prod    = f_ext * i_ext;
    addend  = (state_q == ACC) ? pe.input_psum : prod;
    wide    = {acc_q[PSUM_WIDTH-1], acc_q} + {addend[PSUM_WIDTH-1], addend};
    sum_ovf = (wide[PSUM_WIDTH] != wide[PSUM_WIDTH-1]);
    sum     = wide[PSUM_WIDTH-1:0];
    if (sum_ovf)
      sum = wide[PSUM_WIDTH] ? PSUM_MIN : PSUM_MAX;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pe.start) state_d = LOAD;
      LOAD: if (if_cnt_nx == n_q && (reuse_q || fl_cnt_nx == n_q)) state_d = MAC;
      MAC:  if (idx_q == n_q - CW'(1)) state_d = acc_psum_q ? ACC : OUT;
      ACC:  if (psum_hs) state_d = OUT;
      OUT:  if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      n_q        <= '0;
      if_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      idx_q      <= '0;
      acc_psum_q <= 1'b0;
      reuse_q    <= 1'b0;
      sat_q      <= 1'b0;
      acc_q      <= '0;
      out_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        if_rf[i] <= '0;
        fl_rf[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: if (pe.start) begin
          n_q        <= n_cfg;
          acc_psum_q <= pe.cfg_acc_psum;
          reuse_q    <= pe.cfg_reuse_filter;
          if_cnt_q   <= '0;
          fl_cnt_q   <= '0;
          idx_q      <= '0;
          acc_q      <= '0;
          sat_q      <= 1'b0;
        end
        LOAD: begin
          if (ifmap_hs) begin
            if_rf[if_cnt_q[RF_ADDR_WIDTH-1:0]] <= pe.ifmap;
            if_cnt_q <= if_cnt_nx;
          end
          if (filter_hs) begin
            fl_rf[fl_cnt_q[RF_ADDR_WIDTH-1:0]] <= pe.filter;
            fl_cnt_q <= fl_cnt_nx;
          end
        end
        MAC: begin
          acc_q <= sum;
          sat_q <= sat_q | sum_ovf;
          idx_q <= idx_q + CW'(1);
          if (state_d == OUT) out_q <= sum;
        end
        ACC: if (psum_hs) begin
          acc_q <= sum;
          sat_q <= sat_q | sum_ovf;
          out_q <= sum;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_pe.sv
// Bench for rs_pe: directed vector table, reset-abort sequence, then random jobs vs. an arithmetic model.
module tb_rs_pe;
  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  rs_pe_if #(.DATA_WIDTH(16), .PSUM_WIDTH(32), .RF_ADDR_WIDTH(3)) pe_if ();
  rs_pe #(.DATA_WIDTH(16), .PSUM_WIDTH(32), .RF_ADDR_WIDTH(3)) dut (
    .clk(clk), .rstb(rstb), .pe(pe_if)
  );

  localparam longint PMAX = 64'sd2147483647;
  localparam longint PMIN = -64'sd2147483648;

  int checks = 0;
  int errors = 0;
  int job_if [8];
  int job_fl [8];
  int fl_model [8];

  typedef struct packed {
    int  cfg;
    bit  accf;
    bit  reuse;
    int  psum;
    int  gap;
    int  if_dly;
    int  p_at;
    int  hold;
    int  lat;
    logic [7:0][15:0] iv;
    logic [7:0][15:0] fv;
    int  exp_psum;
    bit  exp_sat;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int clamp_n(input int cfg);
    return (cfg == 0) ? 1 : (cfg > 8) ? 8 : cfg;
  endfunction

  // Dot product with the accumulator clamped after every add.
  function automatic void model(input int n, input bit accf, input bit reuse, input longint psum,
                                output longint res, output bit s);
    longint a = 0;
    s = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) a += longint'(reuse ? fl_model[i] : job_fl[i]) * longint'(job_if[i]);
      else if (accf) a += psum;
      if (a > PMAX) begin a = PMAX; s = 1'b1; end
      if (a < PMIN) begin a = PMIN; s = 1'b1; end
    end
    res = a;
  endfunction

  task automatic idle_inputs();
    pe_if.start = 1'b0; pe_if.cfg_size = '0; pe_if.cfg_acc_psum = 1'b0; pe_if.cfg_reuse_filter = 1'b0;
    pe_if.ifmap_valid = 1'b0; pe_if.ifmap = '0; pe_if.filter_valid = 1'b0; pe_if.filter = '0;
    pe_if.in_psum_valid = 1'b0; pe_if.input_psum = '0; pe_if.out_psum_ready = 1'b0;
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after the transfer.
  task automatic run_job(input string nm, input int cfg, input bit accf, input bit reuse,
                         input longint psum, input int gap, input int if_dly, input int p_at,
                         input int hold, input int lat, input longint exp_psum, input bit exp_sat);
    int n, ii, ff, cyc, psum_hs, out_first, out_wait;
    bit done, fr_seen, acc_bad, unstable, sat_v;
    logic [31:0] first_val;
    n = clamp_n(cfg);
    ii = 0; ff = 0; cyc = 0; psum_hs = 0; out_first = -1; out_wait = 0;
    done = 0; fr_seen = 0; acc_bad = 0; unstable = 0; sat_v = 0; first_val = '0;
    idle_inputs();
    pe_if.start = 1'b1; pe_if.cfg_size = 4'(cfg);
    pe_if.cfg_acc_psum = accf; pe_if.cfg_reuse_filter = reuse;
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      pe_if.start = 1'b0;
      pe_if.ifmap_valid   = (cyc > if_dly) && ($urandom_range(0, 99) >= gap);
      pe_if.ifmap         = (ii < n) ? 16'(job_if[ii % 8]) : 16'($urandom);
      pe_if.filter_valid  = ($urandom_range(0, 99) >= gap);
      pe_if.filter        = (ff < n) ? 16'(job_fl[ff % 8]) : 16'($urandom);
      pe_if.in_psum_valid = (cyc >= p_at);
      pe_if.input_psum    = 32'(psum);
      pe_if.out_psum_ready = pe_if.out_psum_valid && (out_wait >= hold);
      @(negedge clk);
      if (pe_if.ifmap_valid && pe_if.ifmap_ready) ii++;
      if (pe_if.filter_ready) fr_seen = 1'b1;
      if (pe_if.filter_valid && pe_if.filter_ready) ff++;
      if (pe_if.in_psum_valid && pe_if.in_psum_ready) psum_hs++;
      if (accf && cyc >= 2 * n + 1 && cyc <= p_at && !pe_if.in_psum_ready) acc_bad = 1'b1;
      if (pe_if.out_psum_valid) begin
        if (out_first < 0) begin
          out_first = cyc; first_val = pe_if.output_psum; sat_v = pe_if.sat;
        end else if (pe_if.output_psum != first_val || pe_if.sat != sat_v) begin
          unstable = 1'b1;
        end
        if (pe_if.out_psum_ready) done = 1'b1;
        else out_wait++;
      end
    end
    chk({nm, " done"}, longint'(done), 1);
    chk({nm, " psum"}, longint'($signed(first_val)), exp_psum);
    chk({nm, " sat"}, longint'(sat_v), longint'(exp_sat));
    chk({nm, " ifmap_taken"}, ii, n);
    chk({nm, " filter_taken"}, ff, reuse ? 0 : n);
    if (reuse) chk({nm, " filter_ready_seen"}, longint'(fr_seen), 0);
    chk({nm, " psum_taken"}, psum_hs, longint'(accf));
    chk({nm, " out_stable"}, longint'(unstable), 0);
    chk({nm, " xfer_wait"}, out_wait, hold);
    if (lat >= 0) chk({nm, " latency"}, out_first, lat);
    if (accf && gap == 0 && if_dly == 0) chk({nm, " acc_ready_held"}, longint'(acc_bad), 0);
    @(posedge clk); #1;
    chk({nm, " idle_after"}, longint'(pe_if.busy), 0);
    chk({nm, " psum_held"}, longint'($signed(pe_if.output_psum)), exp_psum);
    if (!reuse) for (int i = 0; i < n; i++) fl_model[i] = job_fl[i];
    idle_inputs();
  endtask

  initial begin
    longint res;
    bit s;
    int cfg;
    bit accf, reuse;
    longint psum;

    for (int k = 0; k < 6; k++) vt[k] = '0;
    vt[0].cfg = 3; vt[0].p_at = 1; vt[0].lat = 7; vt[0].exp_psum = 32;
    vt[0].fv[2:0] = {16'd3, 16'd2, 16'd1};
    vt[0].iv[2:0] = {16'd6, 16'd5, 16'd4};
    vt[1] = vt[0]; vt[1].accf = 1'b1; vt[1].psum = -40; vt[1].p_at = 12; vt[1].lat = 13;
    vt[1].exp_psum = -8;
    vt[2].cfg = 3; vt[2].reuse = 1'b1; vt[2].p_at = 1; vt[2].lat = 7; vt[2].exp_psum = 6;
    vt[2].iv[2:0] = {16'd1, 16'd1, 16'd1};
    vt[2].fv[2:0] = {16'd9, 16'd9, 16'd9};
    vt[3].cfg = 8; vt[3].p_at = 1; vt[3].lat = 17; vt[3].exp_psum = 2147483647; vt[3].exp_sat = 1'b1;
    vt[3].iv = {8{16'h8000}};
    vt[3].fv = {8{16'h8000}};
    vt[4].cfg = 0; vt[4].gap = 40; vt[4].if_dly = 6; vt[4].p_at = 1; vt[4].hold = 10;
    vt[4].lat = -1; vt[4].exp_psum = -15;
    vt[4].fv[0] = 16'hFFFD;
    vt[4].iv[0] = 16'd5;
    vt[5].cfg = 12; vt[5].p_at = 1; vt[5].lat = 17; vt[5].exp_psum = 36;
    vt[5].fv = {8{16'd1}};
    vt[5].iv = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

    for (int i = 0; i < 8; i++) fl_model[i] = 0;
    rstb = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", longint'(pe_if.busy), 0);
    chk("reset out_valid", longint'(pe_if.out_psum_valid), 0);
    chk("reset psum", longint'(pe_if.output_psum), 0);
    chk("reset sat", longint'(pe_if.sat), 0);
    chk("reset readies", longint'({pe_if.ifmap_ready, pe_if.filter_ready, pe_if.in_psum_ready}), 0);
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) begin
        job_if[i] = int'($signed(vt[k].iv[i]));
        job_fl[i] = int'($signed(vt[k].fv[i]));
      end
      run_job($sformatf("vec%0d", k), vt[k].cfg, vt[k].accf, vt[k].reuse,
              longint'(int'(vt[k].psum)), vt[k].gap, vt[k].if_dly, vt[k].p_at, vt[k].hold,
              vt[k].lat, longint'(int'(vt[k].exp_psum)), vt[k].exp_sat);
    end

    // Reset asserted in the middle of an N=8 MAC phase.
    pe_if.start = 1'b1; pe_if.cfg_size = 4'd8;
    pe_if.ifmap_valid = 1'b1; pe_if.ifmap = 16'd3;
    pe_if.filter_valid = 1'b1; pe_if.filter = 16'd2;
    pe_if.out_psum_ready = 1'b1;
    @(posedge clk); #1;
    pe_if.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("midmac busy", longint'(pe_if.busy), 1);
    rstb = 1'b0;
    #1;
    chk("rst busy", longint'(pe_if.busy), 0);
    chk("rst psum", longint'(pe_if.output_psum), 0);
    chk("rst out_valid", longint'(pe_if.out_psum_valid), 0);
    chk("rst readies", longint'({pe_if.ifmap_ready, pe_if.filter_ready, pe_if.in_psum_ready}), 0);
    idle_inputs();
    for (int i = 0; i < 8; i++) fl_model[i] = 0;
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    job_if[0] = 7;
    job_fl[0] = 5;
    run_job("rst_reuse", 1, 1'b0, 1'b1, 0, 0, 0, 1, 0, 3, 0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      cfg   = int'($urandom_range(0, 12));
      accf  = 1'($urandom_range(0, 1));
      reuse = ($urandom_range(0, 3) == 0);
      psum  = longint'(int'($urandom));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          job_if[i] = $urandom_range(0, 1) ? 32767 : -32768;
          job_fl[i] = $urandom_range(0, 1) ? 32767 : -32768;
        end else begin
          job_if[i] = int'($urandom_range(0, 65535)) - 32768;
          job_fl[i] = int'($urandom_range(0, 65535)) - 32768;
        end
      end
      model(clamp_n(cfg), accf, reuse, psum, res, s);
      run_job($sformatf("rnd%0d", r), cfg, accf, reuse, psum, int'($urandom_range(0, 50)),
              int'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
              int'($urandom_range(0, 3)), -1, res, s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
